// File: rtl/tcp_tx_arbiter_if.sv
// Handshake bundle between the TCP TX arbiter, its requesters and the shared encoder.
// The master modport is the arbiter side; the slave modport is the requester/encoder side.
interface tcp_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic             enc_fin;
  logic [15:0]      enc_checksum;
  logic [15:0]      enc_len;
  logic [N_REQ-1:0] grant;
  logic [1:0]       sel;
  logic             enc_start;
  logic             enc_reset;
  logic             busy;
  logic [N_REQ-1:0] done;
  logic             err;
  logic [15:0]      res_checksum;
  logic [15:0]      res_len;

  modport master (
    input  req, enc_fin, enc_checksum, enc_len,
    output grant, sel, enc_start, enc_reset, busy, done, err, res_checksum, res_len
  );

  modport slave (
    output req, enc_fin, enc_checksum, enc_len,
    input  grant, sel, enc_start, enc_reset, busy, done, err, res_checksum, res_len
  );
endinterface

// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter that shares one TCP encoder between N_REQ requesters,
// sequencing encoder reset/start and aborting packets that overrun TIMEOUT cycles.
module tcp_tx_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter logic [15:0] TIMEOUT = 16'd2048
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  tcp_tx_arbiter_if.master       bus_io
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e           state_q;
  logic [1:0]       last_q;
  logic [15:0]      cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [1:0]       sel_q;
  logic             enc_start_q;
  logic             enc_reset_q;
  logic             busy_q;
  logic [N_REQ-1:0] done_q;
  logic             err_q;
  logic [15:0]      res_checksum_q;
  logic [15:0]      res_len_q;

  logic             win_found;
  logic [1:0]       win_idx;

  // Search starts just past the last grant; the final step wraps back onto last_q itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!win_found && bus_io.req[last_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = last_q + 2'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      last_q         <= 2'(N_REQ - 1);
      cnt_q          <= '0;
      grant_q        <= '0;
      sel_q          <= '0;
      enc_start_q    <= 1'b0;
      enc_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= '0;
      err_q          <= 1'b0;
      res_checksum_q <= '0;
      res_len_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q     <= StStart;
            grant_q     <= N_REQ'(1) << win_idx;
            sel_q       <= win_idx;
            last_q      <= win_idx;
            enc_start_q <= 1'b1;
            enc_reset_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
          end
        end
        StStart: begin
          state_q     <= StRun;
          enc_start_q <= 1'b0;
        end
        StRun: begin
          // enc_fin takes priority over a timeout landing in the same cycle.
          if (bus_io.enc_fin) begin
            state_q        <= StDone;
            res_checksum_q <= bus_io.enc_checksum;
            res_len_q      <= bus_io.enc_len;
            done_q         <= grant_q;
            err_q          <= 1'b0;
          end else if (cnt_q == TIMEOUT - 16'd1) begin
            state_q <= StDone;
            done_q  <= grant_q;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StDone: begin
          state_q     <= StIdle;
          done_q      <= '0;
          err_q       <= 1'b0;
          grant_q     <= '0;
          busy_q      <= 1'b0;
          enc_reset_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.grant        = grant_q;
  assign bus_io.sel          = sel_q;
  assign bus_io.enc_start    = enc_start_q;
  assign bus_io.enc_reset    = enc_reset_q;
  assign bus_io.busy         = busy_q;
  assign bus_io.done         = done_q;
  assign bus_io.err          = err_q;
  assign bus_io.res_checksum = res_checksum_q;
  assign bus_io.res_len      = res_len_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Self-checking bench for tcp_tx_arbiter: the bench plays requesters and encoder,
// predicting grants, completion timing, err and latched results from a transaction-level model.
module tb_tcp_tx_arbiter;
  localparam logic [15:0] TO = 16'd32;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  tcp_tx_arbiter_if #(.N_REQ(4)) bus ();

  tcp_tx_arbiter #(.N_REQ(4), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: last granted index, last good result, outstanding requests.
  int          m_last = 3;
  logic [15:0] m_cks = 16'h0;
  logic [15:0] m_len = 16'h0;
  logic [3:0]  m_req = 4'h0;

  function automatic int rr_pick(input logic [3:0] r);
    for (int off = 1; off <= 4; off++) begin
      if (r[(m_last + off) % 4]) return (m_last + off) % 4;
    end
    return -1;
  endfunction

  // {grant, sel, enc_start, enc_reset, busy, done, err}
  function automatic logic [13:0] outs();
    return {bus.grant, bus.sel, bus.enc_start, bus.enc_reset, bus.busy, bus.done, bus.err};
  endfunction

  task automatic do_reset();
    m_req = 4'h0;
    bus.req = m_req;
    bus.enc_fin = 1'b0;
    @(negedge clk) rst_ni = 1'b0;
    @(negedge clk) rst_ni = 1'b1;
    m_last = 3;
    m_cks = 16'h0;
    m_len = 16'h0;
  endtask

  // Entered at a negedge in IDLE with bus.req = m_req; returns at the negedge of the IDLE
  // cycle following DONE. k is the RUN cycle index in which enc_fin is driven high.
  task automatic run_packet(input int k, input logic [15:0] cks, input logic [15:0] len,
                            input bit spur_start, input bit drop_run, input logic [3:0] add_done,
                            output int w_o);
    int w, j, exp_j;
    bit exp_err, seen;
    logic [13:0] e;
    logic [41:0] e_done, a_done;
    w = rr_pick(m_req);
    w_o = w;
    if (w < 0) return;
    exp_err = (k > int'(TO) - 1);
    exp_j = exp_err ? int'(TO) - 1 : k;

    @(posedge clk); @(negedge clk);
    e = {4'(1 << w), 2'(w), 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0};
    vectors++;
    if (outs() !== e) begin
      miscompares++;
      $display("FAIL start_state: got %b want %b", outs(), e);
    end
    m_last = w;
    if (spur_start) begin
      bus.enc_fin = 1'b1;
      bus.enc_checksum = 16'hDEAD;
      bus.enc_len = 16'hDEAD;
    end

    @(negedge clk);
    bus.enc_fin = 1'b0;
    vectors++;
    if ({bus.enc_start, bus.busy, bus.done, bus.grant} !== {1'b0, 1'b1, 4'b0000, 4'(1 << w)})
    begin
      miscompares++;
      $display("FAIL run_entry: start=%b busy=%b done=%b grant=%b want 0 1 0000 %b",
               bus.enc_start, bus.busy, bus.done, bus.grant, 4'(1 << w));
    end
    if (drop_run) begin
      m_req[w] = 1'b0;
      bus.req = m_req;
    end

    seen = 1'b0;
    j = 0;
    while (!seen && j < int'(TO) + 4) begin
      bus.enc_fin = (j == k);
      bus.enc_checksum = (j == k) ? cks : 16'($urandom);
      bus.enc_len = (j == k) ? len : 16'($urandom);
      @(negedge clk);
      if (bus.done !== 4'b0000) seen = 1'b1;
      else j++;
    end
    bus.enc_fin = 1'b0;
    vectors++;
    if (!seen || j != exp_j) begin
      miscompares++;
      $display("FAIL run_length: seen=%0d run_cycles=%0d want %0d", seen, j + 1, exp_j + 1);
    end

    if (!exp_err) begin
      m_cks = cks;
      m_len = len;
    end
    e_done = {4'(1 << w), exp_err, 4'(1 << w), 1'b1, m_cks, m_len};
    a_done = {bus.done, bus.err, bus.grant, bus.busy, bus.res_checksum, bus.res_len};
    vectors++;
    if (a_done !== e_done) begin
      miscompares++;
      $display("FAIL done_state: got %h want %h", a_done, e_done);
    end
    m_req[w] = 1'b0;
    m_req = m_req | add_done;
    bus.req = m_req;

    @(negedge clk);
    e = {4'b0000, 2'(w), 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
    vectors++;
    if (outs() !== e || bus.res_checksum !== m_cks || bus.res_len !== m_len) begin
      miscompares++;
      $display("FAIL idle_after_done: got %b res=%h/%h want %b res=%h/%h",
               outs(), bus.res_checksum, bus.res_len, e, m_cks, m_len);
    end
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({outs(), bus.res_checksum, bus.res_len} !== {14'b0000_00_0_1_0_0000_0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_values: got %b res=%h/%h", outs(), bus.res_checksum, bus.res_len);
    end
    @(negedge clk) rst_ni = 1'b1;
    @(negedge clk);
    vectors++;
    if (outs() !== 14'b0000_00_0_1_0_0000_0) begin
      miscompares++;
      $display("FAIL idle_no_req: got %b want 00000001000000", outs());
    end
  endtask

  task automatic test_single();
    int w;
    m_req = 4'b0100;
    bus.req = m_req;
    run_packet(9, 16'hBEEF, 16'd40, 1'b0, 1'b0, 4'b0000, w);
    vectors++;
    if (bus.res_checksum !== 16'hBEEF || bus.res_len !== 16'd40 || w != 2) begin
      miscompares++;
      $display("FAIL single_result: res=%h/%0d owner=%0d want beef/40 owner 2",
               bus.res_checksum, bus.res_len, w);
    end
  endtask

  task automatic test_fairness();
    int w;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    m_req = 4'b1111;
    bus.req = m_req;
    for (int p = 0; p < 5; p++) begin
      run_packet(4, 16'(16'h1000 + p), 16'(p + 1), 1'b0, 1'b0, 4'(1 << exp_order[p]), w);
      vectors++;
      if (w != exp_order[p]) begin
        miscompares++;
        $display("FAIL fairness_order: packet %0d owner %0d want %0d", p, w, exp_order[p]);
      end
    end
    m_req = 4'h0;
    bus.req = m_req;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int w;
    m_req = 4'b0010;
    bus.req = m_req;
    run_packet(1000, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 4'b0000, w);
  endtask

  task automatic test_tie();
    int w;
    m_req = 4'b1000;
    bus.req = m_req;
    run_packet(int'(TO) - 1, 16'h1234, 16'd77, 1'b0, 1'b0, 4'b0000, w);
  endtask

  task automatic test_reset_mid();
    int w;
    m_req = 4'b1000;
    bus.req = m_req;
    @(posedge clk); @(negedge clk); @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({outs(), bus.res_checksum, bus.res_len} !== {14'b0000_00_0_1_0_0000_0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_run: got %b res=%h/%h", outs(), bus.res_checksum, bus.res_len);
    end
    m_req = 4'b0011;
    bus.req = m_req;
    m_last = 3;
    m_cks = 16'h0;
    m_len = 16'h0;
    @(negedge clk) rst_ni = 1'b1;
    run_packet(2, 16'hC0DE, 16'd12, 1'b0, 1'b0, 4'b0000, w);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL reset_priority: first owner %0d want 0", w);
    end
    m_req = 4'h0;
    bus.req = m_req;
    @(negedge clk);
  endtask

  task automatic test_robust();
    int w;
    logic [11:0] a;
    m_req = 4'h0;
    bus.req = m_req;
    for (int c = 0; c < 3; c++) begin
      bus.enc_fin = 1'b1;
      @(negedge clk);
      a = {bus.grant, bus.enc_start, bus.enc_reset, bus.busy, bus.done, bus.err};
      vectors++;
      if (a !== 12'b0000_0_1_0_0000_0) begin
        miscompares++;
        $display("FAIL idle_spurious_fin: got %b want 000001000000", a);
      end
    end
    bus.enc_fin = 1'b0;
    m_req = 4'b0100;
    bus.req = m_req;
    run_packet(6, 16'h7777, 16'd9, 1'b1, 1'b1, 4'b0000, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL single_done_pulse: done=%b busy=%b want 0000 0", bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    int w, k;
    for (int n = 0; n < 40; n++) begin
      if (m_req == 4'h0) m_req = 4'($urandom_range(1, 15));
      bus.req = m_req;
      k = ($urandom_range(0, 7) == 0) ? 60 : int'($urandom_range(0, 12));
      run_packet(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom) & 4'($urandom), w);
    end
  endtask

  initial begin
    bus.req = 4'h0;
    bus.enc_fin = 1'b0;
    bus.enc_checksum = 16'h0;
    bus.enc_len = 16'h0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_robust();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tcp_tx_arbiter.md
TCP_TX_ARBITER -- requirements
Module: tcp_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one TCP encoder (fixed 4 in this revision; sel is 2 bits).
REQ-002 Parameter TIMEOUT, default 16'd2048, maximum RUN cycles allowed before the packet is aborted.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  level request per requester; held high until that requester's done pulse.
REQ-006 enc_fin  input  1  encoder fin flag.
REQ-007 enc_checksum  input  16  encoder checksum_out.
REQ-008 enc_len  input  16  encoder len_out.
REQ-009 grant  output  N_REQ  one-hot owner of the encoder; all-zero when idle.
REQ-010 sel  output  2  binary index of the owner; drives the header/data input muxes of the encoder.
REQ-011 enc_start  output  1  encoder start pulse.
REQ-012 enc_reset  output  1  encoder reset (active-high); clears the encoder and its checksum accumulators.
REQ-013 busy  output  1  high while a packet is in flight.
REQ-014 done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-015 err  output  1  qualifies done; high means the packet was aborted on timeout.
REQ-016 res_checksum  output  16  latched checksum of the last good packet.
REQ-017 res_len  output  16  latched length of the last good packet.

Function
REQ-018 The FSM SHALL have four states, IDLE, START, RUN and DONE, and all outputs SHALL be registered.
REQ-019 IDLE: enc_reset=1, grant=0, busy=0; on an edge with |req, state->START, grant/sel <= winner, enc_start<=1, enc_reset<=0, busy<=1, timeout counter<=0.
REQ-020 Arbitration SHALL be round-robin: the search starts at (last granted index + 1) mod N_REQ, and the pointer updates only on grant.
REQ-021 START lasts exactly one cycle, then state->RUN with enc_start<=0, giving a start pulse exactly one cycle wide that coincides with enc_reset=0.
REQ-022 RUN: the counter increments each cycle; on enc_fin=1, state->DONE, res_checksum<=enc_checksum, res_len<=enc_len, done[sel]<=1, err<=0.
REQ-023 RUN: if the counter == TIMEOUT-1 and enc_fin=0, state->DONE, done[sel]<=1, err<=1, and res_* are unchanged.
REQ-024 If enc_fin and the timeout occur in the same cycle, enc_fin SHALL win (err=0).
REQ-025 DONE lasts one cycle, then state->IDLE with done<=0, err<=0, grant<=0, sel unchanged, busy<=0, enc_reset<=1.
REQ-026 IDLE SHALL last at least one cycle between packets so the encoder sees enc_reset for at least one cycle.
REQ-027 enc_fin SHALL be ignored outside RUN.
REQ-028 req changes while not in IDLE SHALL be ignored; a dropped req SHALL NOT abort the in-flight packet.
REQ-029 A req asserted during DONE SHALL be arbitrated on the IDLE edge that follows.
REQ-030 The minimum request-to-start latency SHALL be one edge (req seen in IDLE -> enc_start high the next cycle).

Reset
REQ-031 While reset=0, the block SHALL immediately force: state=IDLE, grant=0, sel=0, enc_start=0, enc_reset=1, busy=0, done=0, err=0, res_checksum=0, res_len=0, counter=0, and the round-robin pointer set so requester 0 has first priority.
REQ-032 A reset asserted mid-packet SHALL abort without a done pulse, and the encoder is cleared through enc_reset.

Verification
REQ-033 Single request: req=4'b0100, enc_fin rises 10 cycles after enc_start with checksum 16'hBEEF and len 16'd40 -> grant=4'b0100, sel=2, one-cycle enc_start, done=4'b0100 for one cycle, err=0, res_checksum=16'hBEEF, res_len=40, then IDLE with enc_reset=1.
REQ-034 Fairness: req=4'b1111 held with enc_fin after 5 cycles each -> grants in order 0,1,2,3,0 with at least one IDLE cycle between grants.
REQ-035 Timeout: TIMEOUT=32, enc_fin never asserted -> done[sel] with err=1 after 32 RUN cycles, res_* unchanged, enc_reset=1 the next cycle.
REQ-036 Tie: enc_fin rises exactly at counter==TIMEOUT-1 -> err=0 and res_* captured.
REQ-037 Reset mid-RUN: reset low -> all outputs at their reset values immediately (asynchronously); after release with req=4'b0011, requester 0 is granted first.
REQ-038 Robustness: req dropped during RUN plus a spurious enc_fin during START or IDLE -> packet completes normally with a single done pulse, and the spurious enc_fin causes no transition.
